branch_update_unit: RTL and testbench

BRANCH_UPDATE_UNIT -- requirements
Module: branch_update_unit

---
 rtl/branch_update_unit.sv | 192 +++++++++++++++++++
 tb/tb_branch_update_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_update_unit
// Description : Initialises a 2-bit-counter PHT to weakly-not-taken, then
//               drains a FIFO of resolved-branch updates through a two-stage
//               read (R) / write (W) pipeline, one update per cycle.
//               Optional build macro BRANCH_UPDATE_FORWARD_EN: when defined,
//               a same-index R/W hazard is resolved by forwarding the W-stage
//               value; when undefined, R stalls one cycle instead.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_update_unit #(
  parameter int PHT_INDEX_WIDTH = 10,
  parameter int PC_WIDTH        = 32,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [PC_WIDTH-1:0]        upd_pc,
  input  logic [PHT_INDEX_WIDTH-1:0] upd_ghr,
  input  logic                       upd_taken,
  output logic                       pht_rd_en,
  output logic [PHT_INDEX_WIDTH-1:0] pht_rd_index,
  input  logic [1:0]                 pht_rd_data,
  output logic                       pht_wr_en,
  output logic [PHT_INDEX_WIDTH-1:0] pht_wr_index,
  output logic [1:0]                 pht_wr_data,
  output logic                       init_done,
  output logic                       busy
);

  localparam int             PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(QUEUE_DEPTH);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                     state_q;
  logic [PHT_INDEX_WIDTH-1:0] init_idx_q;
  logic                       init_done_q;

  // Update FIFO: index and direction per entry, pointers carry a wrap bit
  logic [PHT_INDEX_WIDTH-1:0] q_idx_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]     q_taken_q;
  logic [PTR_W:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]             rd_ptr_q, rd_ptr_d;

  // W stage: the entry whose PHT read was issued last cycle
  logic                       w_valid_q, w_valid_d;
  logic [PHT_INDEX_WIDTH-1:0] w_idx_q, w_idx_d;
  logic                       w_taken_q, w_taken_d;
`ifdef BRANCH_UPDATE_FORWARD_EN
  logic                       w_fwd_q, w_fwd_d;
  logic [1:0]                 w_fwd_val_q, w_fwd_val_d;
`endif

  logic                       run;
  logic                       init_act;
  logic                       q_empty;
  logic                       q_full;
  logic [PTR_W:0]             q_count;
  logic                       push;
  logic                       rd_go;
  logic                       hazard;
  logic [PHT_INDEX_WIDTH-1:0] head_idx;
  logic                       head_taken;
  logic [PHT_INDEX_WIDTH-1:0] enq_idx;
  logic                       w_fire;
  logic [1:0]                 w_old;
  logic [1:0]                 w_new;
  logic                       unused_pc_bits;

  assign unused_pc_bits = ^{upd_pc[PC_WIDTH-1:PHT_INDEX_WIDTH+2], upd_pc[1:0]};

  // Queue status, hazard detection, pipeline next-state and output muxing.
  // Combinational outputs are forced low while rst is high.
  always_comb begin
    run        = (state_q == ST_RUN) && !rst;
    init_act   = (state_q == ST_INIT) && !rst;
    q_count    = wr_ptr_q - rd_ptr_q;
    q_empty    = (wr_ptr_q == rd_ptr_q);
    q_full     = (q_count == DEPTH);
    head_idx   = q_idx_q[rd_ptr_q[PTR_W-1:0]];
    head_taken = q_taken_q[rd_ptr_q[PTR_W-1:0]];
    enq_idx    = upd_pc[PHT_INDEX_WIDTH+1:2] ^ upd_ghr;

    upd_ready  = run && !q_full;
    push       = upd_valid && upd_ready;
    w_fire     = run && w_valid_q;
    hazard     = w_fire && (head_idx == w_idx_q);

`ifdef BRANCH_UPDATE_FORWARD_EN
    rd_go      = run && !q_empty;
    w_old      = w_fwd_q ? w_fwd_val_q : pht_rd_data;
`else
    rd_go      = run && !q_empty && !hazard;
    w_old      = pht_rd_data;
`endif

    // Saturating 2-bit counter update
    if (w_taken_q) w_new = (w_old == 2'b11) ? 2'b11 : w_old + 2'b01;
    else           w_new = (w_old == 2'b00) ? 2'b00 : w_old - 2'b01;

    wr_ptr_d  = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = rd_go ? rd_ptr_q + 1'b1 : rd_ptr_q;
    w_valid_d = rd_go;
    w_idx_d   = head_idx;
    w_taken_d = head_taken;
`ifdef BRANCH_UPDATE_FORWARD_EN
    w_fwd_d     = rd_go && hazard;
    w_fwd_val_d = w_new;
`endif

    pht_rd_en    = rd_go;
    pht_rd_index = rd_go ? head_idx : '0;

    pht_wr_en    = 1'b0;
    pht_wr_index = '0;
    pht_wr_data  = 2'b00;
    if (init_act) begin
      pht_wr_en    = 1'b1;
      pht_wr_index = init_idx_q;
      pht_wr_data  = 2'b01;
    end else if (w_fire) begin
      pht_wr_en    = 1'b1;
      pht_wr_index = w_idx_q;
      pht_wr_data  = w_new;
    end

    busy      = !rst && (!q_empty || w_valid_q);
    init_done = init_done_q;
  end

  // INIT walks every PHT index once, then RUN until the next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_idx_q <= init_idx_q + 1'b1;
          if (&init_idx_q) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

  // Queue pointers and W-stage registers; reset drops all pending work
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      w_valid_q   <= 1'b0;
      w_idx_q     <= '0;
      w_taken_q   <= 1'b0;
`ifdef BRANCH_UPDATE_FORWARD_EN
      w_fwd_q     <= 1'b0;
      w_fwd_val_q <= 2'b00;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      w_valid_q   <= w_valid_d;
      w_idx_q     <= w_idx_d;
      w_taken_q   <= w_taken_d;
`ifdef BRANCH_UPDATE_FORWARD_EN
      w_fwd_q     <= w_fwd_d;
      w_fwd_val_q <= w_fwd_val_d;
`endif
    end
  end

  // Queue storage needs no reset: pointers define which slots are live
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx_q[wr_ptr_q[PTR_W-1:0]]   <= enq_idx;
      q_taken_q[wr_ptr_q[PTR_W-1:0]] <= upd_taken;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_update_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_update_unit
// Description : Self-checking bench for branch_update_unit. A PHT memory
//               model answers reads one cycle later; a reference model keeps
//               the expected PHT and an ordered list of expected writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_update_unit;

  localparam int IW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          upd_valid = 1'b0;
  logic [31:0]   upd_pc = '0;
  logic [IW-1:0] upd_ghr = '0;
  logic          upd_taken = 1'b0;
  logic          upd_ready, pht_rd_en, pht_wr_en, init_done, busy;
  logic [IW-1:0] pht_rd_index, pht_wr_index;
  logic [1:0]    pht_rd_data = 2'b00;
  logic [1:0]    pht_wr_data;

  // Small instance used only for the 16-entry initialisation sequence
  logic          s_ready, s_rd_en, s_wr_en, s_init_done, s_busy;
  logic [3:0]    s_rd_index, s_wr_index;
  logic [1:0]    s_wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_update_unit #(.PHT_INDEX_WIDTH(IW), .PC_WIDTH(32), .QUEUE_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .pht_rd_en(pht_rd_en), .pht_rd_index(pht_rd_index), .pht_rd_data(pht_rd_data),
    .pht_wr_en(pht_wr_en), .pht_wr_index(pht_wr_index), .pht_wr_data(pht_wr_data),
    .init_done(init_done), .busy(busy)
  );

  branch_update_unit #(.PHT_INDEX_WIDTH(4), .PC_WIDTH(32), .QUEUE_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .upd_valid(1'b0), .upd_ready(s_ready),
    .upd_pc(32'h0), .upd_ghr(4'h0), .upd_taken(1'b0),
    .pht_rd_en(s_rd_en), .pht_rd_index(s_rd_index), .pht_rd_data(2'b00),
    .pht_wr_en(s_wr_en), .pht_wr_index(s_wr_index), .pht_wr_data(s_wr_data),
    .init_done(s_init_done), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // PHT memory: read data returned one cycle after the request (read-first)
  logic [1:0] mem [N];
  always @(posedge clk) begin
    if (pht_rd_en) pht_rd_data <= mem[pht_rd_index];
    if (pht_wr_en) mem[pht_wr_index] <= pht_wr_data;
  end

  // Reference model: expected PHT after every accepted update, applied in
  // acceptance order; each acceptance yields exactly one expected write.
  typedef struct {int c; logic [IW-1:0] idx; logic [1:0] data;} ev_t;
  ev_t        exp_q[$];
  ev_t        wlog[$];
  ev_t        rlog[$];
  logic [1:0] ref_pht [N];
  int         mi;

  function automatic logic [1:0] sat(input logic [1:0] v, input logic t);
    int x;
    x = t ? int'(v) + 1 : int'(v) - 1;
    if (x > 3) x = 3;
    if (x < 0) x = 0;
    return 2'(x);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < N; i++) ref_pht[i] = 2'b01;
    end else begin
      if (upd_valid && upd_ready) begin
        mi = int'(((upd_pc / 4) ^ 32'(upd_ghr)) % N);
        ref_pht[mi] = sat(ref_pht[mi], upd_taken);
        exp_q.push_back('{cyc, IW'(mi), ref_pht[mi]});
      end
      if (pht_rd_en) rlog.push_back('{cyc, pht_rd_index, 2'b00});
      if (pht_wr_en && init_done) begin
        wlog.push_back('{cyc, pht_wr_index, pht_wr_data});
        if (exp_q.size() == 0) check("unexpected_write", 32'(pht_wr_index), 32'hFFFF);
        else begin
          check("wr_index", 32'(pht_wr_index), 32'(exp_q[0].idx));
          check("wr_data",  32'(pht_wr_data),  32'(exp_q[0].data));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Offer one update; returns the acceptance cycle (-1 if never accepted)
  task automatic send(input int idx, input logic tk, output int acc);
    upd_pc    = 32'(idx) << 2;
    upd_ghr   = '0;
    upd_taken = tk;
    upd_valid = 1'b1;
    acc = -1;
    for (int n = 0; n < 50 && acc < 0; n++) begin
      @(negedge clk);
      if (upd_ready) acc = cyc;
      @(posedge clk); #1;
    end
    upd_valid = 1'b0;
    if (acc < 0) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  int acc, acc0, span, exp_span, accepted;
  logic saw_low, exp_low;

  initial begin
    // ---------------- reset and initialisation ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {upd_ready, pht_rd_en, pht_wr_en, init_done, busy}, 32'd0);
    check("rst_buses", {pht_rd_index, pht_wr_index, pht_wr_data}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("init_wr", {pht_wr_en, pht_wr_index, pht_wr_data}, {1'b1, 5'(i), 2'b01});
      check("init_hold", {upd_ready, init_done, pht_rd_en}, 32'd0);
      if (i < 16) check("init16_wr", {s_wr_en, s_wr_index, s_wr_data}, {1'b1, 4'(i), 2'b01});
      else if (i == 16) check("init16_done", {s_init_done, s_ready, s_wr_en}, 32'b110);
    end
    @(negedge clk);
    check("init_done", {init_done, upd_ready, pht_wr_en}, 32'b110);
    @(posedge clk); #1;

    // ---------------- single update latency ----------------
    rlog.delete(); wlog.delete();
    upd_pc = 32'h40; upd_ghr = 5'h03; upd_taken = 1'b1; upd_valid = 1'b1;
    @(negedge clk); acc = cyc;
    check("lat_ready", 32'(upd_ready), 32'd1);
    @(posedge clk); #1 upd_valid = 1'b0;
    wait_idle();
    if (rlog.size() > 0 && wlog.size() > 0) begin
      check("lat_rd", {32'(rlog[0].c - acc), 27'd0, rlog[0].idx}, {32'd1, 27'd0, 5'h13});
      check("lat_wr", 32'(wlog[0].c - acc), 32'd2);
      check("lat_wr_val", {wlog[0].idx, wlog[0].data}, {5'h13, 2'b10});
    end else check("lat_events", 32'(wlog.size()), 32'd1);

    // ---------------- saturation ----------------
    wlog.delete();
    send(7, 1'b1, acc); send(7, 1'b1, acc);             // 01 -> 10 -> 11
    for (int k = 0; k < 4; k++) send(7, 1'b1, acc);
    send(9, 1'b0, acc);                                 // 01 -> 00
    for (int k = 0; k < 3; k++) send(9, 1'b0, acc);
    wait_idle();
    if (wlog.size() == 10) begin
      for (int k = 2; k < 6; k++)  check("sat_up", 32'(wlog[k].data), 32'd3);
      for (int k = 7; k < 10; k++) check("sat_dn", 32'(wlog[k].data), 32'd0);
    end else check("sat_count", 32'(wlog.size()), 32'd10);

    // ---------------- back-to-back same index ----------------
    wlog.delete();
    send(5, 1'b1, acc0); send(5, 1'b1, acc);
    wait_idle();
`ifdef BRANCH_UPDATE_FORWARD_EN
    exp_span = 2;
`else
    exp_span = 3;
`endif
    if (wlog.size() == 2) begin
      span = wlog[1].c - wlog[0].c + 1;
      check("b2b_data", {wlog[0].data, wlog[1].data}, {2'b10, 2'b11});
      check("b2b_span", 32'(span), 32'(exp_span));
      check("b2b_first", 32'(wlog[0].c - acc0), 32'd2);
    end else check("b2b_count", 32'(wlog.size()), 32'd2);

    // ---------------- throughput, distinct indices ----------------
    wlog.delete();
    for (int k = 0; k < 8; k++) begin
      send(16 + k, k[0], acc);
      if (k == 0) acc0 = acc;
    end
    check("tput_accept", 32'(acc - acc0), 32'd7);
    wait_idle();
    if (wlog.size() == 8)
      for (int k = 1; k < 8; k++) check("tput_wr", 32'(wlog[k].c - wlog[0].c), 32'(k));
    else check("tput_count", 32'(wlog.size()), 32'd8);

    // ---------------- full queue on same-index traffic ----------------
    saw_low = 1'b0; accepted = 0;
    upd_pc = 32'h0A << 2; upd_ghr = '0; upd_taken = 1'b0; upd_valid = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (!upd_ready) saw_low = 1'b1; else accepted++;
      @(posedge clk); #1;
    end
    upd_valid = 1'b0;
`ifdef BRANCH_UPDATE_FORWARD_EN
    exp_low = 1'b0;
`else
    exp_low = 1'b1;
`endif
    check("full_ready_low", 32'(saw_low), 32'(exp_low));
    wait_idle();

    // ---------------- randomized traffic ----------------
    for (int k = 0; k < 300; k++) begin
      upd_valid = ($urandom_range(3) != 0);
      upd_pc    = $urandom;
      upd_ghr   = IW'($urandom);
      upd_taken = 1'($urandom);
      @(posedge clk); #1;
    end
    upd_valid = 1'b0;
    wait_idle();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < N; i++) check("pht_final", 32'(mem[i]), 32'(ref_pht[i]));

    // ---------------- reset with pending updates ----------------
    wlog.delete();
    upd_ghr = '0; upd_taken = 1'b1; upd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      upd_pc = 32'(20 + k) << 2;
      if (k == 2) rst = 1'b1;
      @(negedge clk);
      if (k == 2) check("mid_rst_out", {pht_wr_en, pht_rd_en, upd_ready, busy}, 32'd0);
      @(posedge clk); #1;
    end
    upd_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_out2", {pht_wr_en, init_done, busy, pht_wr_index, pht_wr_data}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reinit_idx0", {pht_wr_en, pht_wr_index, pht_wr_data, init_done}, {1'b1, 5'd0, 2'b01, 1'b0});
    repeat (N) @(negedge clk);
    check("reinit_done", 32'(init_done), 32'd1);
    check("rst_dropped", 32'(wlog.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
